// File: rtl/multi_lane_requantizer.sv
// multi_lane_requantizer
// Requantizes LANES signed int32 accumulators to signed OUT_W-bit values:
// saturating left shift, Q31 rounding-doubling high multiply (pipelined over
// MUL_STAGES registers), rounding right shift, zero-point add with int32
// saturation, then clamp to the activation bounds. Total latency is
// MUL_STAGES+4 cycles; one vector per cycle; the whole pipe freezes on stall.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   in_valid/in_ready input handshake (in_ready = !out_valid || out_ready)
//   in_x, in_mult     per-lane int32 accumulator / Q31 multiplier
//   in_shift          per-lane signed 6-bit shift (+left / -right)
//   in_zp             shared int32 output zero point
//   in_act_min/max    shared OUT_W-bit signed clamp bounds
//   out_valid/ready   output handshake
//   out_data          per-lane OUT_W-bit signed results
module multi_lane_requantizer #(
    parameter int LANES      = 4,
    parameter int OUT_W      = 8,
    parameter int MUL_STAGES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*32-1:0]    in_x,
    input  logic [LANES*32-1:0]    in_mult,
    input  logic [LANES*6-1:0]     in_shift,
    input  logic [31:0]            in_zp,
    input  logic [OUT_W-1:0]       in_act_min,
    input  logic [OUT_W-1:0]       in_act_max,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data
);

    localparam int L  = MUL_STAGES + 4;
    // Stages that carry shared config and shift amounts (all but the output stage).
    localparam int CD = L - 1;

    logic [L-1:0]            valid_q;
    logic [31:0]             zp_q   [CD];
    logic [OUT_W-1:0]        mn_q   [CD];
    logic [OUT_W-1:0]        mx_q   [CD];
    logic [5:0]              sh_q   [CD][LANES];
    logic [31:0]             x1_q   [LANES];
    logic [31:0]             m1_q   [LANES];
    logic [31:0]             xs2_q  [LANES];
    logic [31:0]             m2_q   [LANES];
    logic                    sp2_q  [LANES];
    logic [63:0]             prod_q [MUL_STAGES][LANES];
    logic                    sp_q   [MUL_STAGES][LANES];
    logic [31:0]             high_q [LANES];
    logic [LANES*OUT_W-1:0]  out_data_q;
    logic [31:0]             xs_d   [LANES];
    logic                    en_s;

    // -32 cannot be negated in 6 bits, so it is folded onto -31.
    function automatic logic [5:0] norm_shift(input logic [5:0] s);
        if (s == 6'b100000) norm_shift = 6'b100001;
        else                norm_shift = s;
    endfunction

    function automatic logic [4:0] left_amt(input logic [5:0] s);
        if (s[5]) left_amt = 5'd0;
        else      left_amt = s[4:0];
    endfunction

    function automatic logic [4:0] right_amt(input logic [5:0] s);
        logic [5:0] n;
        n = 6'd0 - s;
        if (s[5]) right_amt = n[4:0];
        else      right_amt = 5'd0;
    endfunction

    function automatic logic [31:0] sat_shl(input logic [31:0] x, input logic [4:0] amt);
        logic signed [63:0] w;
        w = $signed({{32{x[31]}}, x}) <<< amt;
        if (w > 64'sd2147483647)       sat_shl = 32'h7FFF_FFFF;
        else if (w < -64'sd2147483648) sat_shl = 32'h8000_0000;
        else                           sat_shl = w[31:0];
    endfunction

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        mul64 = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    endfunction

    // (prod + nudge) / 2^31 truncated toward zero: bias negatives before the shift.
    function automatic logic [31:0] high_of(input logic [63:0] prod, input logic sp);
        logic signed [63:0] t;
        t = $signed(prod) + (prod[63] ? -64'sd1073741823 : 64'sd1073741824);
        if (t[63]) t = t + 64'sd2147483647;
        else       t = t;
        if (sp) high_of = 32'h7FFF_FFFF;
        else    high_of = t[62:31];
    endfunction

    // Rounding right shift (half away from zero), zero-point add, saturate, clamp.
    function automatic logic [OUT_W-1:0] requant(input logic [31:0] high, input logic [4:0] right,
                                                 input logic [31:0] zp, input logic [OUT_W-1:0] mn,
                                                 input logic [OUT_W-1:0] mx);
        logic [31:0]        mask, rem, thr;
        logic signed [31:0] res, sat, lo, hi, cl;
        logic signed [32:0] sum;
        mask = ~(32'hFFFF_FFFF << right);
        rem  = high & mask;
        thr  = {1'b0, mask[31:1]} + {31'd0, high[31]};
        res  = ($signed(high) >>> right) + ((rem > thr) ? 32'sd1 : 32'sd0);
        sum  = $signed({res[31], res}) + $signed({zp[31], zp});
        if (sum > 33'sd2147483647)       sat = 32'sh7FFF_FFFF;
        else if (sum < -33'sd2147483648) sat = 32'sh8000_0000;
        else                             sat = sum[31:0];
        lo = {{(32-OUT_W){mn[OUT_W-1]}}, mn};
        hi = {{(32-OUT_W){mx[OUT_W-1]}}, mx};
        if (sat < lo)      cl = lo;
        else if (sat > hi) cl = hi;
        else               cl = sat;
        requant = cl[OUT_W-1:0];
    endfunction

    assign en_s      = !valid_q[L-1] || out_ready;
    assign in_ready  = en_s;
    assign out_valid = valid_q[L-1];
    assign out_data  = out_data_q;

    // Saturated left-shifted accumulator for the second stage.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            xs_d[i] = sat_shl(x1_q[i], left_amt(sh_q[0][i]));
        end
    end

    // Pipeline: capture, shift, multiply, high-mul, finalize; frozen when en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            out_data_q <= '0;
        end else if (en_s) begin
            valid_q <= {valid_q[L-2:0], in_valid};
            zp_q[0] <= in_zp;
            mn_q[0] <= in_act_min;
            mx_q[0] <= in_act_max;
            for (int k = 1; k < CD; k++) begin
                zp_q[k] <= zp_q[k-1];
                mn_q[k] <= mn_q[k-1];
                mx_q[k] <= mx_q[k-1];
            end
            for (int i = 0; i < LANES; i++) begin
                x1_q[i]    <= in_x[32*i +: 32];
                m1_q[i]    <= in_mult[32*i +: 32];
                sh_q[0][i] <= norm_shift(in_shift[6*i +: 6]);
                for (int k = 1; k < CD; k++) begin
                    sh_q[k][i] <= sh_q[k-1][i];
                end
                xs2_q[i] <= xs_d[i];
                m2_q[i]  <= m1_q[i];
                sp2_q[i] <= (xs_d[i] == 32'h8000_0000) && (m1_q[i] == 32'h8000_0000);
                prod_q[0][i] <= mul64(xs2_q[i], m2_q[i]);
                sp_q[0][i]   <= sp2_q[i];
                for (int s = 1; s < MUL_STAGES; s++) begin
                    prod_q[s][i] <= prod_q[s-1][i];
                    sp_q[s][i]   <= sp_q[s-1][i];
                end
                high_q[i] <= high_of(prod_q[MUL_STAGES-1][i], sp_q[MUL_STAGES-1][i]);
                out_data_q[OUT_W*i +: OUT_W] <= requant(high_q[i], right_amt(sh_q[CD-1][i]),
                                                        zp_q[CD-1], mn_q[CD-1], mx_q[CD-1]);
            end
        end
    end

endmodule

// File: tb/tb_multi_lane_requantizer.sv
// Testbench for multi_lane_requantizer: scenario tasks drive vectors, push
// model results to a scoreboard queue, and a negedge monitor pops/compares
// every transferred output.
module tb_multi_lane_requantizer;

    localparam int LANES      = 4;
    localparam int OUT_W      = 8;
    localparam int MUL_STAGES = 3;
    localparam int L          = MUL_STAGES + 4;
    localparam longint IMAX   = 64'sd2147483647;
    localparam longint IMIN   = -64'sd2147483648;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*32-1:0]    in_x = '0;
    logic [LANES*32-1:0]    in_mult = '0;
    logic [LANES*6-1:0]     in_shift = '0;
    logic [31:0]            in_zp = '0;
    logic [OUT_W-1:0]       in_act_min = '0;
    logic [OUT_W-1:0]       in_act_max = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [LANES*OUT_W-1:0] out_data;

    logic [LANES*OUT_W-1:0] sb[$];
    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int vx[LANES], vm[LANES], vsh[LANES];
    int vzp, vmn, vmx;

    multi_lane_requantizer #(.LANES(LANES), .OUT_W(OUT_W), .MUL_STAGES(MUL_STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_mult(in_mult), .in_shift(in_shift), .in_zp(in_zp),
        .in_act_min(in_act_min), .in_act_max(in_act_max),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] ref_lane(int x, int m, int sh, int zp, int mn, int mx);
        longint xs, prod, nudge, high, mask, rem, thr, res, s;
        int left, right;
        if (sh == -32) sh = -31;
        left  = (sh > 0) ? sh : 0;
        right = (sh < 0) ? -sh : 0;
        xs = longint'(x) <<< left;
        if (xs > IMAX) xs = IMAX;
        else if (xs < IMIN) xs = IMIN;
        if (xs == IMIN && longint'(m) == IMIN) begin
            high = IMAX;
        end else begin
            prod  = xs * longint'(m);
            nudge = (prod >= 0) ? 64'sd1073741824 : -64'sd1073741823;
            high  = (prod + nudge) / 64'sd2147483648;
        end
        mask = (64'sd1 <<< right) - 64'sd1;
        rem  = high & mask;
        thr  = (mask >>> 1) + ((high < 0) ? 64'sd1 : 64'sd0);
        res  = (high >>> right) + ((rem > thr) ? 64'sd1 : 64'sd0);
        s = res + longint'(zp);
        if (s > IMAX) s = IMAX;
        else if (s < IMIN) s = IMIN;
        if (s < longint'(mn)) s = longint'(mn);
        else if (s > longint'(mx)) s = longint'(mx);
        ref_lane = s[OUT_W-1:0];
    endfunction

    function automatic logic [LANES*OUT_W-1:0] exp_vec();
        logic [LANES*OUT_W-1:0] e;
        for (int i = 0; i < LANES; i++)
            e[OUT_W*i +: OUT_W] = ref_lane(vx[i], vm[i], vsh[i], vzp, vmn, vmx);
        return e;
    endfunction

    task automatic drive_vec(input logic v);
        for (int i = 0; i < LANES; i++) begin
            in_x[32*i +: 32]    = vx[i];
            in_mult[32*i +: 32] = vm[i];
            in_shift[6*i +: 6]  = vsh[i][5:0];
        end
        in_zp      = vzp;
        in_act_min = vmn[OUT_W-1:0];
        in_act_max = vmx[OUT_W-1:0];
        in_valid   = v;
    endtask

    // Drive the current vector until accepted; returns 1 ns after the accepting edge.
    task automatic send_vec();
        bit ok;
        ok = 1'b0;
        drive_vec(1'b1);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_vec());
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_accept: in_ready never high, required accept within 50 cycles");
        end
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic check_latency(input string name);
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (k == L - 1)) begin
                errors++;
                $display("FAIL %s_latency: cycle %0d out_valid %b, required %b", name, k + 1, out_valid, (k == L - 1));
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: every transferred output must match the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [LANES*OUT_W-1:0] e;
        if (rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got %h, required no output", out_data);
            end else begin
                e = sb.pop_front();
                pops++;
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %h, required %h", out_data, e);
                end
            end
        end
    end

    task automatic base_cfg();
        vzp = 0; vmn = -128; vmx = 127;
        for (int i = 0; i < LANES; i++) begin
            vx[i] = 0; vm[i] = 32'h4000_0000; vsh[i] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        base_cfg();
        vx[0] = 100;
        vx[1] = -60;
        vx[2] = 200; vsh[2] = -1;
        vx[3] = 7;   vm[3] = 32'h7FFF_FFFF;
        checks++;
        if (ref_lane(100, 32'h4000_0000, 0, 0, -128, 127) !== 8'd50) begin
            errors++; $display("FAIL basic_model: got %0d, required 50", ref_lane(100, 32'h4000_0000, 0, 0, -128, 127));
        end
        send_vec();
        check_latency("basic");
        drain("basic");
    endtask

    task automatic test_rounding();
        base_cfg();
        vx[0] = 102;  vsh[0] = -1;
        vx[1] = -102; vsh[1] = -1;
        vx[2] = 999;  vsh[2] = -32;
        vx[3] = -77;  vsh[3] = -3;
        send_vec();
        drain("rounding");
    endtask

    task automatic test_clamp();
        base_cfg();
        vzp = -10;
        vx[0] = 100;          vsh[0] = 2;
        vx[1] = 32'h7FFF_FFFF; vsh[1] = 4;
        vx[2] = 32'h8000_0000; vsh[2] = 4;
        vx[3] = -3;            vsh[3] = 0;
        send_vec();
        vmn = -20; vmx = 20; vzp = 5;
        vx[3] = 30; vx[2] = -90;
        send_vec();
        drain("clamp");
    endtask

    task automatic test_special();
        base_cfg();
        vx[0] = 32'h8000_0000; vm[0] = 32'h8000_0000;
        vx[1] = 32'h8000_0000; vm[1] = 32'h7FFF_FFFF; vsh[1] = -24;
        vx[2] = 55;            vm[2] = 32'h8000_0000;
        vx[3] = -1234;         vm[3] = 32'h2000_0000; vsh[3] = -2;
        send_vec();
        drain("special");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            vzp = int'($urandom_range(0, 200)) - 100;
            vmn = -int'($urandom_range(1, 128));
            vmx = int'($urandom_range(0, 127));
            for (int i = 0; i < LANES; i++) begin
                vx[i]  = $urandom;
                vm[i]  = $urandom;
                vsh[i] = int'($urandom_range(0, 40)) - 32;
            end
            send_vec();
        end
        drain("random");
    endtask

    task automatic test_back_to_back();
        int sent, c, p0;
        logic [LANES*OUT_W-1:0] held;
        sent = 0; c = 0; p0 = pops; held = '0;
        base_cfg();
        while (sent < 8 && c < 100) begin
            out_ready = !(c >= 8 && c <= 10);
            for (int i = 0; i < LANES; i++) vx[i] = 30 * sent + 13 * i - 100;
            drive_vec(!(c == 2 || c == 5));
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(exp_vec());
                sent++;
            end
            if (!out_ready && out_valid) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
                if (c == 8) held = out_data;
                else begin
                    checks++;
                    if (out_data !== held) begin errors++; $display("FAIL stall_hold: got %h, required %h", out_data, held); end
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("back_to_back");
        checks++;
        if (pops - p0 != 8) begin errors++; $display("FAIL b2b_count: got %0d results, required 8", pops - p0); end
    endtask

    task automatic test_reset_flush();
        base_cfg();
        for (int n = 0; n < 3; n++) begin
            vx[0] = 10 * n + 4;
            send_vec();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
        for (int k = 0; k < 2 * L; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: cycle %0d got %b, required 0", k, out_valid); end
            @(posedge clk);
            #1;
        end
        vx[0] = -40; vx[1] = 66;
        send_vec();
        check_latency("flush");
        drain("flush");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_clamp();
        test_special();
        test_random();
        test_back_to_back();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
